// File: rtl/map_pkg.sv
// -----------------------------------------------------------------------------
// map_pkg
// Shared constants and types for the tile-map scheduler:
//   - tile geometry (TILE_PX, TILE_SHIFT)
//   - default map size, RAM address width and code width
//   - sprite code enumeration used by the tile map contents
//   - arbiter state type for the map RAM port arbiter
// -----------------------------------------------------------------------------
package map_pkg;

    localparam int TILE_PX       = 8;
    localparam int TILE_SHIFT    = 3;
    localparam int TILE_COLS_DEF = 28;
    localparam int TILE_ROWS_DEF = 36;
    localparam int ADDR_W_DEF    = 10;
    localparam int CODE_W_DEF    = 4;

    typedef enum logic [3:0] {
        EMPTY      = 4'd0,
        WALL_H_BOT = 4'd1,
        WALL_V_L   = 4'd2,
        WALL_H_MID = 4'd3,
        WALL_V_R   = 4'd4,
        CORNER_TL  = 4'd5,
        CORNER_TR  = 4'd6,
        CORNER_BL  = 4'd7,
        CORNER_BR  = 4'd8
    } sprite_code_e;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GL_ISSUE = 2'd1,
        ARB_GL_WAIT  = 2'd2
    } arb_state_e;

    // Pixel position within its 8-pixel tile span.
    function automatic logic [TILE_SHIFT-1:0] tile_phase(input logic [9:0] pix);
        return pix[TILE_SHIFT-1:0];
    endfunction

endpackage

// File: rtl/map_port_arbiter.sv
// -----------------------------------------------------------------------------
// map_port_arbiter
// Owns the single map-RAM port. The renderer fetch has strict priority; a game
// access is accepted only when the port is idle, no fetch is requested and the
// caller does not block it. All RAM strobes are registered, so a game access
// occupies the port only in the GL_ISSUE cycle and a renderer fetch can always
// be registered in any state without clashing.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fetch_req       renderer fetch request this cycle (wins over game)
//   fetch_addr      renderer tile address
//   gl_block        game acceptance blocked (tile boundary too close)
//   gl_wr_ok        game writes may be accepted this cycle
//   gl_req/we/addr/wdata   game request, held until gl_ack
//   ram_addr/re/we/wdata   registered RAM port
//   ram_rdata       synchronous RAM read data
//   gl_ack          one-cycle completion pulse
//   gl_rdata        read data, valid with gl_ack (0 for writes/out-of-range)
// -----------------------------------------------------------------------------
module map_port_arbiter
    import map_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CODE_W    = CODE_W_DEF,
    parameter int MAP_TILES = TILE_COLS_DEF * TILE_ROWS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              gl_block,
    input  logic              gl_wr_ok,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [CODE_W-1:0] gl_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [CODE_W-1:0] ram_wdata,
    input  logic [CODE_W-1:0] ram_rdata,
    output logic              gl_ack,
    output logic [CODE_W-1:0] gl_rdata
);

    localparam logic [ADDR_W:0] MAP_TILES_W = (ADDR_W+1)'(MAP_TILES);

    arb_state_e        state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_re_q, ram_re_d;
    logic              ram_we_q, ram_we_d;
    logic [CODE_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              gl_ack_q, gl_ack_d;
    logic              gl_in_range_s;
    logic              gl_accept_s;

    // Next-state, acceptance and RAM strobe mux.
    always_comb begin
        state_d     = state_q;
        rd_valid_d  = rd_valid_q;
        ram_addr_d  = '0;
        ram_re_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_wdata_d = '0;
        gl_ack_d    = 1'b0;

        gl_in_range_s = ({1'b0, gl_addr} < MAP_TILES_W);
        gl_accept_s   = (state_q == ARB_IDLE) && gl_req && !fetch_req && !gl_block &&
                        (!gl_we || gl_wr_ok);

        // Renderer first; an out-of-range game access is acknowledged without touching the RAM.
        if (fetch_req) begin
            ram_addr_d = fetch_addr;
            ram_re_d   = 1'b1;
        end else if (gl_accept_s && gl_in_range_s) begin
            ram_addr_d  = gl_addr;
            ram_re_d    = !gl_we;
            ram_we_d    = gl_we;
            ram_wdata_d = gl_we ? gl_wdata : {CODE_W{1'b0}};
        end else begin
            ram_addr_d = '0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (gl_accept_s) begin
                    state_d    = ARB_GL_ISSUE;
                    rd_valid_d = !gl_we && gl_in_range_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GL_ISSUE: begin
                state_d  = ARB_GL_WAIT;
                gl_ack_d = 1'b1;
            end
            ARB_GL_WAIT: begin
                state_d    = ARB_IDLE;
                rd_valid_d = 1'b0;
            end
            default: begin
                state_d    = ARB_IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // Arbiter state and registered RAM/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rd_valid_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            gl_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_valid_d;
            ram_addr_q  <= ram_addr_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            gl_ack_q    <= gl_ack_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_re    = ram_re_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign gl_ack    = gl_ack_q;
    // RAM data only exists in the ack cycle, so it is gated by registered qualifiers.
    assign gl_rdata  = (gl_ack_q && rd_valid_q) ? ram_rdata : {CODE_W{1'b0}};

endmodule

// File: rtl/map_tile_scheduler.sv
// -----------------------------------------------------------------------------
// map_tile_scheduler
// Walks the pixel stream, fetches one tile code per 8-pixel span from the map
// RAM and delivers sx/sy/sprite_code/de_out to the renderer with a 3-cycle
// latency. Game logic shares the RAM port through map_port_arbiter.
//
// Optional build macro: MAP_BLANK_ONLY_WRITE_EN
//   defined   - game writes accepted only while de_in == 0
//   undefined - game writes accepted whenever the port is free
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   pix_x, pix_y, de_in current pixel and active-video flag
//   sx, sy              pixel position within tile, 3 cycles delayed
//   sprite_code         tile code for the delayed pixel (0 outside map)
//   de_out              pixel valid and inside the map, 3 cycles delayed
//   ram_*               registered map RAM port, ram_rdata one cycle after ram_re
//   gl_*                game access handshake
// -----------------------------------------------------------------------------
module map_tile_scheduler
    import map_pkg::*;
#(
    parameter int TILE_COLS = TILE_COLS_DEF,
    parameter int TILE_ROWS = TILE_ROWS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CODE_W    = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              de_in,
    output logic [2:0]        sx,
    output logic [2:0]        sy,
    output logic [CODE_W-1:0] sprite_code,
    output logic              de_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [CODE_W-1:0] ram_wdata,
    input  logic [CODE_W-1:0] ram_rdata,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [CODE_W-1:0] gl_wdata,
    output logic              gl_ack,
    output logic [CODE_W-1:0] gl_rdata
);

    localparam logic [9:0]        MAP_W_PX   = 10'(TILE_COLS * TILE_PX);
    localparam logic [9:0]        MAP_H_PX   = 10'(TILE_ROWS * TILE_PX);
    localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(EMPTY);

    logic              in_map_s;
    logic              fetch_s;
    logic              gl_block_s;
    logic              gl_wr_ok_s;
    logic [ADDR_W-1:0] tile_addr_s;

    logic [2:0]        sx_p1_q, sx_p1_d, sy_p1_q, sy_p1_d;
    logic              in_map_p1_q, in_map_p1_d, fetch_p1_q, fetch_p1_d;
    logic [2:0]        sx_p2_q, sx_p2_d, sy_p2_q, sy_p2_d;
    logic              in_map_p2_q, in_map_p2_d, fetch_p2_q, fetch_p2_d;
    logic [CODE_W-1:0] code_hold_q, code_hold_d;
    logic [2:0]        sx_q, sx_d, sy_q, sy_d;
    logic              de_out_q, de_out_d;
    logic [CODE_W-1:0] sprite_code_q, sprite_code_d;

    // Map-area decode, fetch trigger, game blocking window and tile address.
    always_comb begin
        in_map_s    = de_in && (pix_x < MAP_W_PX) && (pix_y < MAP_H_PX);
        fetch_s     = in_map_s && (tile_phase(pix_x) == 3'd0);
        // Accepting at phase 6/7 would leave the game access in flight at the next boundary.
        gl_block_s  = in_map_s && (tile_phase(pix_x) >= 3'd6);
        tile_addr_s = ADDR_W'(pix_y >> TILE_SHIFT) * ADDR_W'(TILE_COLS) +
                      ADDR_W'(pix_x >> TILE_SHIFT);
`ifdef MAP_BLANK_ONLY_WRITE_EN
        gl_wr_ok_s  = !de_in;
`else
        gl_wr_ok_s  = 1'b1;
`endif
    end

    // Pixel pipeline: stage 1 = RAM address presented, stage 2 = RAM data valid,
    // output stage = code register loaded.
    always_comb begin
        sx_p1_d     = tile_phase(pix_x);
        sy_p1_d     = tile_phase(pix_y);
        in_map_p1_d = in_map_s;
        fetch_p1_d  = fetch_s;

        sx_p2_d     = sx_p1_q;
        sy_p2_d     = sy_p1_q;
        in_map_p2_d = in_map_p1_q;
        fetch_p2_d  = fetch_p1_q;

        code_hold_d = fetch_p2_q ? ram_rdata : code_hold_q;

        sx_d          = sx_p2_q;
        sy_d          = sy_p2_q;
        de_out_d      = in_map_p2_q;
        // The held code survives out-of-map pixels; only the output is blanked.
        sprite_code_d = in_map_p2_q ? code_hold_d : CODE_BLANK;
    end

    // Pixel pipeline and code registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_p1_q       <= 3'd0;
            sy_p1_q       <= 3'd0;
            in_map_p1_q   <= 1'b0;
            fetch_p1_q    <= 1'b0;
            sx_p2_q       <= 3'd0;
            sy_p2_q       <= 3'd0;
            in_map_p2_q   <= 1'b0;
            fetch_p2_q    <= 1'b0;
            code_hold_q   <= '0;
            sx_q          <= 3'd0;
            sy_q          <= 3'd0;
            de_out_q      <= 1'b0;
            sprite_code_q <= '0;
        end else begin
            sx_p1_q       <= sx_p1_d;
            sy_p1_q       <= sy_p1_d;
            in_map_p1_q   <= in_map_p1_d;
            fetch_p1_q    <= fetch_p1_d;
            sx_p2_q       <= sx_p2_d;
            sy_p2_q       <= sy_p2_d;
            in_map_p2_q   <= in_map_p2_d;
            fetch_p2_q    <= fetch_p2_d;
            code_hold_q   <= code_hold_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            de_out_q      <= de_out_d;
            sprite_code_q <= sprite_code_d;
        end
    end

    assign sx          = sx_q;
    assign sy          = sy_q;
    assign de_out      = de_out_q;
    assign sprite_code = sprite_code_q;

    map_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .CODE_W    (CODE_W),
        .MAP_TILES (TILE_COLS * TILE_ROWS)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_s),
        .fetch_addr (tile_addr_s),
        .gl_block   (gl_block_s),
        .gl_wr_ok   (gl_wr_ok_s),
        .gl_req     (gl_req),
        .gl_we      (gl_we),
        .gl_addr    (gl_addr),
        .gl_wdata   (gl_wdata),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .gl_ack     (gl_ack),
        .gl_rdata   (gl_rdata)
    );

endmodule

// File: tb/tb_map_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_map_tile_scheduler
// Scoreboard bench: stimulus tasks push hand-computed expectations (pixel
// outputs, RAM strobes, game acks) tagged with the cycle they are due; a
// negedge monitor compares them against the DUT. A behavioural synchronous
// RAM sits on the map port.
// -----------------------------------------------------------------------------
module tb_map_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pix_x = 10'd0, pix_y = 10'd0;
    logic       de_in = 1'b0;
    logic [2:0] sx, sy;
    logic [3:0] sprite_code;
    logic       de_out;
    logic [9:0] ram_addr;
    logic       ram_re, ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic       gl_req = 1'b0, gl_we = 1'b0;
    logic [9:0] gl_addr = 10'd0;
    logic [3:0] gl_wdata = 4'd0;
    logic       gl_ack;
    logic [3:0] gl_rdata;

    map_tile_scheduler dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .de_in(de_in),
        .sx(sx), .sy(sy), .sprite_code(sprite_code), .de_out(de_out),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr),
        .gl_wdata(gl_wdata), .gl_ack(gl_ack), .gl_rdata(gl_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural map RAM, loaded with the hand-chosen map on the first cycle.
    logic [3:0] mem [0:1023];
    logic       ram_init = 1'b1;

    function automatic logic [3:0] preset(input int a);
        case (a)
            28:      return 4'h7;
            29:      return 4'h8;
            56:      return 4'h1;
            57:      return 4'h2;
            59:      return 4'h5;
            100:     return 4'h3;
            1007:    return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= preset(i);
            ram_rdata <= 4'h0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    // Scoreboard storage.
    typedef struct { int cyc; logic de; logic [2:0] sx; logic [2:0] sy; logic [3:0] code; } pix_exp_t;
    typedef struct { logic we; logic [9:0] addr; logic [3:0] wdata; } strobe_exp_t;
    typedef struct { int cyc; logic [3:0] rdata; } ack_exp_t;

    pix_exp_t    pq[$];
    ack_exp_t    gq[$];
    strobe_exp_t st_exp[int];

    int nchk = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        nchk++;
        nfail++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel; expected outputs are due 3 cycles later, a fetch strobe 1 cycle later.
    task automatic pix(input int x, input int y, input logic de, input logic exp_de,
                       input int exp_code, input int fetch_addr);
        pix_exp_t e;
        pix_x = 10'(x);
        pix_y = 10'(y);
        de_in = de;
        e.cyc  = cyc + 3;
        e.de   = exp_de;
        e.sx   = 3'(x & 7);
        e.sy   = 3'(y & 7);
        e.code = 4'(exp_code);
        pq.push_back(e);
        if (fetch_addr >= 0) st_exp[cyc + 1] = '{1'b0, 10'(fetch_addr), 4'h0};
        next_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(0, 0, 1'b0, 1'b0, 0, -1);
    endtask

    // Game access: expect ack lat cycles after request, RAM strobe one cycle before it.
    task automatic gl_access(input logic we, input int addr, input int wdata,
                             input int exp_rdata, input int lat, input logic strobe);
        int s = cyc;
        bit got = 1'b0;
        gl_req   = 1'b1;
        gl_we    = we;
        gl_addr  = 10'(addr);
        gl_wdata = 4'(wdata);
        gq.push_back('{s + lat, 4'(exp_rdata)});
        if (strobe) st_exp[s + lat - 1] = '{we, 10'(addr), we ? 4'(wdata) : 4'h0};
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gl_ack) got = 1'b1;
        end
        next_cycle();
        gl_req = 1'b0; gl_we = 1'b0; gl_addr = 10'd0; gl_wdata = 4'd0;
        if (!got) fail_now("gl_ack_timeout", 0, 1);
    endtask

    // Monitor: compares every due expectation at the negedge.
    pix_exp_t    pe;
    strobe_exp_t se;
    ack_exp_t    ge;
    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            fail_now("pix_not_checked", cyc, pq[0].cyc);
            void'(pq.pop_front());
        end
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            pe = pq.pop_front();
            check("de_out", 32'(de_out), 32'(pe.de));
            check("sx", 32'(sx), 32'(pe.sx));
            check("sy", 32'(sy), 32'(pe.sy));
            check("sprite_code", 32'(sprite_code), 32'(pe.code));
        end
        if (ram_re && ram_we) fail_now("strobe_exclusive", 1, 0);
        if (ram_re || ram_we) begin
            if (st_exp.exists(cyc)) begin
                se = st_exp[cyc];
                st_exp.delete(cyc);
                check("ram_we", 32'(ram_we), 32'(se.we));
                check("ram_re", 32'(ram_re), 32'(!se.we));
                check("ram_addr", 32'(ram_addr), 32'(se.addr));
                if (se.we) check("ram_wdata", 32'(ram_wdata), 32'(se.wdata));
            end else begin
                fail_now("unexpected_strobe", int'(ram_addr), -1);
            end
        end else if (st_exp.exists(cyc)) begin
            fail_now("missing_strobe", -1, int'(st_exp[cyc].addr));
            st_exp.delete(cyc);
        end
        if (gl_ack) begin
            if (gq.size() > 0) begin
                ge = gq.pop_front();
                check("gl_ack_cycle", 32'(cyc), 32'(ge.cyc));
                check("gl_rdata", 32'(gl_rdata), 32'(ge.rdata));
            end else begin
                fail_now("unexpected_gl_ack", 1, 0);
            end
        end else if (gq.size() > 0 && gq[0].cyc < cyc) begin
            fail_now("missing_gl_ack", cyc, gq[0].cyc);
            void'(gq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

`ifdef MAP_BLANK_ONLY_WRITE_EN
    localparam int BLANK_WR_LAT = 7;
`else
    localparam int BLANK_WR_LAT = 2;
`endif

    initial begin
        int s;
        next_cycle();
        ram_init = 1'b0;
        next_cycle();
        next_cycle();
        check("reset_outputs", {sx, sy, sprite_code, de_out, ram_addr, ram_re, ram_we,
                                ram_wdata, gl_ack, gl_rdata}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Tile at (24,16) -> address 59, code 5 over the whole span.
        for (int i = 0; i < 8; i++) pix(24 + i, 16, 1'b1, 1'b1, 5, (i == 0) ? 59 : -1);
        idle(3);

        // Last map tile, then pixels just outside the map.
        pix(216, 280, 1'b1, 1'b1, 8, 1007);
        pix(223, 287, 1'b1, 1'b1, 8, -1);
        pix(224, 0, 1'b1, 1'b0, 0, -1);
        pix(0, 288, 1'b1, 1'b0, 0, -1);
        idle(4);

        // Game read at phase 2 between fetches of tiles 28 and 29.
        fork
            begin
                for (int i = 0; i < 16; i++)
                    pix(i, 8, 1'b1, 1'b1, (i < 8) ? 7 : 8, (i == 0) ? 28 : ((i == 8) ? 29 : -1));
                idle(1);
            end
            begin
                next_cycle();
                next_cycle();
                gl_access(1'b0, 100, 0, 3, 2, 1'b1);
            end
        join
        idle(4);

        // Game read colliding with a fetch: one extra cycle of latency.
        fork
            begin
                for (int i = 0; i < 16; i++)
                    pix(i, 16, 1'b1, 1'b1, (i < 8) ? 1 : 2, (i == 0) ? 56 : ((i == 8) ? 57 : -1));
                idle(1);
            end
            begin
                gl_access(1'b0, 100, 0, 3, 3, 1'b1);
            end
        join
        idle(4);

        // Out-of-range write: normal ack, no strobe; then in-range write and read-back.
        gl_access(1'b1, 1008, 15, 0, 2, 1'b0);
        gl_access(1'b1, 200, 9, 0, 2, 1'b1);
        gl_access(1'b0, 200, 0, 9, 2, 1'b1);
        gl_access(1'b0, 1008, 0, 0, 2, 1'b0);
        idle(2);

        // Write issued during active video; with blank-only writes it waits for de_in=0.
        fork
            begin
                for (int i = 0; i < 6; i++) pix(i, 24, 1'b1, 1'b1, 0, (i == 0) ? 84 : -1);
                idle(8);
            end
            begin
                next_cycle();
                gl_access(1'b1, 300, 10, 0, BLANK_WR_LAT, 1'b1);
            end
        join
        gl_access(1'b0, 300, 0, 10, 2, 1'b1);
        idle(3);

        // Reset while the arbiter is in GL_WAIT: outputs clear at once, ack never appears.
        s = cyc;
        gl_req  = 1'b1;
        gl_we   = 1'b0;
        gl_addr = 10'd100;
        st_exp[s + 1] = '{1'b0, 10'd100, 4'h0};
        next_cycle();
        next_cycle();
        check("ack_pending_before_reset", 32'(gl_ack), 32'd1);
        rst     = 1'b1;
        gl_req  = 1'b0;
        gl_addr = 10'd0;
        #1;
        check("reset_in_wait_outputs", {sx, sy, sprite_code, de_out, ram_addr, ram_re, ram_we,
                                        ram_wdata, gl_ack, gl_rdata}, 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        idle(5);
        gl_access(1'b0, 59, 0, 5, 2, 1'b1);
        idle(4);
        repeat (4) next_cycle();

        if (pq.size() != 0) fail_now("pixel_queue_leftover", pq.size(), 0);
        if (gq.size() != 0) fail_now("ack_queue_leftover", gq.size(), 0);
        if (st_exp.num() != 0) fail_now("strobe_leftover", st_exp.num(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/map_tile_scheduler.md
Name: map_tile_scheduler

Overview:
- Sequences the tile-map RAM for the per-pixel sprite renderer.
- Walks the incoming pixel stream and fetches one tile code per 8-pixel tile span.
- Delivers sx/sy/sprite_code/de aligned to the renderer inputs.
- Shares the single map-RAM port with game logic (pellet eat/read), giving the renderer strict priority.

Parameters:
TILE_COLS, 28, map width in 8x8 tiles
TILE_ROWS, 36, map height in tiles
ADDR_W, 10, map RAM address width; must satisfy 2^ADDR_W >= TILE_COLS*TILE_ROWS
CODE_W, 4, tile/sprite code width

Ports:
clk  in  1  pixel clock, one pixel per cycle
rst  in  1  asynchronous, active-high reset
pix_x  in  10  current pixel column
pix_y  in  10  current pixel row
de_in  in  1  active-video pixel
sx  out  3  pixel column within tile (pix_x[2:0], delayed)
sy  out  3  pixel row within tile (pix_y[2:0], delayed)
sprite_code  out  CODE_W  tile code for the current pixel
de_out  out  1  pixel valid and inside map area, delayed
ram_addr  out  ADDR_W  map RAM address, registered
ram_re  out  1  read strobe, registered
ram_we  out  1  write strobe, registered
ram_wdata  out  CODE_W  write data, registered
ram_rdata  in  CODE_W  synchronous read data, valid the cycle after ram_re is presented
gl_req  in  1  game access request, held until gl_ack
gl_we  in  1  1 = write, 0 = read; stable while gl_req
gl_addr  in  ADDR_W  game tile address; stable while gl_req
gl_wdata  in  CODE_W  game write data
gl_ack  out  1  one-cycle completion pulse
gl_rdata  out  CODE_W  read data, valid with gl_ack

Behaviour:
- Reset (asynchronous): all outputs 0; arbiter to IDLE; in-flight access abandoned with no gl_ack.
- Map area: pix_x < TILE_COLS*8 and pix_y < TILE_ROWS*8.
- in_map = de_in && inside map area.
- Fetch condition (cycle t): in_map && pix_x[2:0]==0.
  - Tile address = (pix_y>>3)*TILE_COLS + (pix_x>>3), computed at ADDR_W width.
  - Address and ram_re=1 are registered, so they are presented in cycle t+1.
  - ram_rdata is valid in cycle t+2.
  - The code register loads it; sprite_code is valid from cycle t+3 and holds until the next fetch load.
- Pixel pipeline: sx, sy and de_out (=in_map) are delayed exactly 3 cycles. Total latency pixel-in to renderer-in is 3 cycles.
- Out of map: de_out=0 and sprite_code=0 on that pixel's output cycle; no fetch issued.
- Arbiter states:
  - IDLE: if fetch condition holds, serve renderer. Else, if gl_req (and permitted, see Optional Feature), latch gl_we/gl_addr/gl_wdata and go to GL_ISSUE.
  - GL_ISSUE: RAM strobes for the game access are presented this cycle; go to GL_WAIT.
  - GL_WAIT: assert gl_ack, with gl_rdata = ram_rdata for reads and 0 for writes; go to IDLE.
- Game timing: ack arrives 2 cycles after acceptance. A new request can be accepted no earlier than the cycle after gl_ack.
- Collision: a fetch condition arising while in GL_ISSUE/GL_WAIT cannot occur. Acceptance is blocked when in_map && pix_x[2:0]==6 or 7, so a game access always completes before the next tile boundary.
- Simultaneous fetch and gl_req: renderer wins; gl_req stays pending.
- Address range: gl_addr >= TILE_COLS*TILE_ROWS is acknowledged on the normal schedule with gl_rdata=0, and no RAM strobe is issued.
- Strobe exclusivity: ram_re and ram_we are never both 1; at most one requester per cycle.

Optional Feature:
- Macro: MAP_BLANK_ONLY_WRITE_EN.
- Defined: game writes are accepted only when de_in==0, preventing mid-frame map tearing. Game reads follow the normal rules.
- Undefined: writes are accepted whenever the port is free, the same as reads.

Decomposition:
- Package map_pkg:
  - TILE_PX=8 and TILE_SHIFT=3
  - default TILE_COLS/TILE_ROWS
  - CODE_W
  - sprite code enum: EMPTY=0, WALL_H_BOT=1, WALL_V_L=2, WALL_H_MID=3, WALL_V_R=4, CORNERs=5..8
  - arbiter state typedef
- Sub-module: map_port_arbiter, containing the IDLE/GL_ISSUE/GL_WAIT FSM and the RAM strobe mux.
- Pixel pipeline and address computation stay in the top level.

Test Plan:
1. Map holds 4'h5 at addr 59; stream pixel (24,16) with de_in=1 → ram_addr=59 with ram_re in cycle +1. Cycles +3..+10 show sprite_code=5, sx=0..7, sy=0, de_out=1.
2. Pixel (224,0), which is outside a 28-column map → no ram_re; 3 cycles later de_out=0 and sprite_code=0.
3. gl_req read of addr 100 (value 4'h3) while pix_x[2:0]=2 → gl_ack 2 cycles after acceptance with gl_rdata=3; no clash with the fetch at the next x%8==0.
4. gl_req asserted in the same cycle as the fetch condition → renderer read presented first; game access accepted the next cycle; gl_ack one cycle later than it would be with no collision.
5. gl_req write of addr 1008 → gl_ack on the normal schedule, gl_rdata=0, ram_we never asserted.
6. Assert rst during GL_WAIT → all outputs 0 immediately, no gl_ack. With MAP_BLANK_ONLY_WRITE_EN, a write issued with de_in=1 waits until de_in=0, then acks 2 cycles later.
